// File: rtl/preif_fetch_sched.sv
// Pre-IF next-PC scheduler: picks the {pc2,pc1} fetch pair and issues it on the inst-bus address handshake.
// Optional perf counters are compiled in with `define PREIF_PERF_CNT_EN.
module preif_fetch_sched #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h1c00_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              excep_flush_i,
  input  logic [PC_W-1:0]   excep_pc_i,
  input  logic              ertn_flush_i,
  input  logic [PC_W-1:0]   era_pc_i,
  input  logic              br_taken_i,
  input  logic [PC_W-1:0]   br_target_i,
  input  logic              idle_i,
  input  logic              if_allowin_i,
  output logic              inst_req_o,
  output logic [PC_W-1:0]   inst_addr_o,
  input  logic              inst_addr_ok_i,
  output logic              preif_to_if_valid_o,
  output logic [2*PC_W-1:0] preif_to_ibus_o
`ifdef PREIF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_redir_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_IDLE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] pend_pc;
  logic            pend_v;
  logic            redir;
  logic            fire;
  logic [PC_W-1:0] redir_pc;

  assign redir    = excep_flush_i | ertn_flush_i | br_taken_i;
  assign redir_pc = excep_flush_i ? excep_pc_i :
                    ertn_flush_i  ? era_pc_i   : br_target_i;

  // Request is suppressed on any redirect cycle so a stale pending target never fires.
  always_comb begin
    state_nxt  = state;
    inst_req_o = 1'b0;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (idle_i && !redir) state_nxt = S_IDLE;
        else                  inst_req_o = if_allowin_i & ~redir;
      end
      S_IDLE:  if (excep_flush_i) state_nxt = S_FETCH;
      default: state_nxt = S_BOOT;
    endcase
  end

  assign fire                = inst_req_o & inst_addr_ok_i;
  assign preif_to_if_valid_o = fire;
  assign inst_addr_o         = pend_v ? pend_pc : seq_pc;
  assign preif_to_ibus_o     = {inst_addr_o + PC_W'(4), inst_addr_o};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_BOOT;
      seq_pc  <= RESET_PC;
      pend_v  <= 1'b0;
      pend_pc <= '0;
    end else begin
      state <= state_nxt;
      if (redir) begin
        pend_v  <= 1'b1;
        pend_pc <= redir_pc;
      end else if (fire) begin
        pend_v  <= 1'b0;
      end
      if (fire) seq_pc <= inst_addr_o + PC_W'(8);
    end
  end

`ifdef PREIF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_redir_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (redir && perf_redir_cnt_o != 32'hffff_ffff)
        perf_redir_cnt_o <= perf_redir_cnt_o + 32'd1;
      if (state == S_FETCH && inst_req_o && !inst_addr_ok_i && perf_stall_cnt_o != 32'hffff_ffff)
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_preif_fetch_sched.sv
// Scenario bench for preif_fetch_sched: expected fetch pairs queued as stimulus is driven, popped on each fire.
module tb_preif_fetch_sched;
  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        excep_flush_i, ertn_flush_i, br_taken_i, idle_i, if_allowin_i, inst_addr_ok_i;
  logic [31:0] excep_pc_i, era_pc_i, br_target_i;
  logic        inst_req_o, preif_to_if_valid_o;
  logic [31:0] inst_addr_o;
  logic [63:0] preif_to_ibus_o;
`ifdef PREIF_PERF_CNT_EN
  logic [31:0] perf_redir_cnt_o, perf_stall_cnt_o;
`endif

  int          passed = 0;
  int          total  = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  preif_fetch_sched dut (
    .clk(clk), .rst_n(rst_n),
    .excep_flush_i(excep_flush_i), .excep_pc_i(excep_pc_i),
    .ertn_flush_i(ertn_flush_i), .era_pc_i(era_pc_i),
    .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .idle_i(idle_i), .if_allowin_i(if_allowin_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o), .inst_addr_ok_i(inst_addr_ok_i),
    .preif_to_if_valid_o(preif_to_if_valid_o), .preif_to_ibus_o(preif_to_ibus_o)
`ifdef PREIF_PERF_CNT_EN
    , .perf_redir_cnt_o(perf_redir_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Samples mid-cycle; every fire must match the oldest queued pair.
  task automatic mon();
    logic [31:0] e;
    @(negedge clk);
    if (preif_to_if_valid_o) begin
      total++;
      if (sb.size() == 0)
        $display("FAIL sb_unexpected_fire got pc1=%h want no fire", inst_addr_o);
      else begin
        e = sb.pop_front();
        if (preif_to_ibus_o !== {e + 32'd4, e})
          $display("FAIL sb_pair got=%h want=%h", preif_to_ibus_o, {e + 32'd4, e});
        else passed++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; excep_flush_i = 0; ertn_flush_i = 0; br_taken_i = 0; idle_i = 0;
    excep_pc_i = '0; era_pc_i = '0; br_target_i = '0; if_allowin_i = 1; inst_addr_ok_i = 1;
    mon();
    total++; if (inst_req_o !== 1'b0) $display("FAIL rst_req got=%b want=0", inst_req_o); else passed++;
    total++; if (preif_to_if_valid_o !== 1'b0) $display("FAIL rst_valid got=%b want=0", preif_to_if_valid_o); else passed++;
    total++; if (preif_to_ibus_o !== {RST_PC + 32'd4, RST_PC})
      $display("FAIL rst_ibus got=%h want=%h", preif_to_ibus_o, {RST_PC + 32'd4, RST_PC}); else passed++;
    step();
    rst_n = 1'b1;
    mon();
    total++; if (inst_req_o !== 1'b0) $display("FAIL boot_req got=%b want=0", inst_req_o); else passed++;
    step();
  endtask

  task automatic test_seq();
    sb.push_back(RST_PC); sb.push_back(RST_PC + 32'd8); sb.push_back(RST_PC + 32'd16);
    repeat (3) begin
      mon();
      total++; if (preif_to_if_valid_o !== 1'b1) $display("FAIL seq_fire got=%b want=1", preif_to_if_valid_o); else passed++;
      step();
    end
  endtask

  task automatic test_branch();
    br_taken_i = 1; br_target_i = 32'h1c00_0100;
    sb.push_back(32'h1c00_0100); sb.push_back(32'h1c00_0108);
    mon();
    total++; if (preif_to_if_valid_o !== 1'b0) $display("FAIL br_nofire got=%b want=0", preif_to_if_valid_o); else passed++;
    step();
    br_taken_i = 0;
    mon();
    total++; if (preif_to_if_valid_o !== 1'b1) $display("FAIL br_fire got=%b want=1", preif_to_if_valid_o); else passed++;
    step(); mon(); step();
  endtask

  task automatic test_priority();
    excep_flush_i = 1; excep_pc_i = 32'h1c00_8000; br_taken_i = 1; br_target_i = 32'h1c00_0200;
    sb.push_back(32'h1c00_8000);
    mon();
    total++; if (inst_req_o !== 1'b0) $display("FAIL prio_req got=%b want=0", inst_req_o); else passed++;
    step();
    excep_flush_i = 0; br_taken_i = 0;
    mon();
    total++; if (preif_to_if_valid_o !== 1'b1) $display("FAIL prio_fire got=%b want=1", preif_to_if_valid_o); else passed++;
    step();
  endtask

  task automatic test_stall();
    sb.push_back(32'h1c00_8008);
    inst_addr_ok_i = 0;
    for (int i = 0; i < 3; i++) begin
      mon();
      total++; if (inst_addr_o !== 32'h1c00_8008 || inst_req_o !== 1'b1 || preif_to_if_valid_o !== 1'b0)
        $display("FAIL stall_hold cyc=%0d got addr=%h req=%b vld=%b want addr=1c008008 req=1 vld=0",
                 i, inst_addr_o, inst_req_o, preif_to_if_valid_o);
      else passed++;
      step();
    end
    inst_addr_ok_i = 1;
    mon();
    total++; if (preif_to_if_valid_o !== 1'b1) $display("FAIL stall_release got=%b want=1", preif_to_if_valid_o); else passed++;
    step();
    sb.push_back(32'h1c00_8010);
    mon(); step();
  endtask

  task automatic test_idle();
    idle_i = 1;
    mon();
    total++; if (inst_req_o !== 1'b0) $display("FAIL idle_enter_req got=%b want=0", inst_req_o); else passed++;
    step();
    idle_i = 0;
    repeat (3) begin
      mon();
      total++; if (inst_req_o !== 1'b0) $display("FAIL idle_hold_req got=%b want=0", inst_req_o); else passed++;
      step();
    end
    br_taken_i = 1; br_target_i = 32'h1c00_0200;
    mon(); step();
    br_taken_i = 0;
    repeat (2) begin
      mon();
      total++; if (inst_req_o !== 1'b0) $display("FAIL idle_br_wake got=%b want=0", inst_req_o); else passed++;
      step();
    end
    excep_flush_i = 1; excep_pc_i = 32'h1c00_1000;
    sb.push_back(32'h1c00_1000); sb.push_back(32'h1c00_1008);
    mon(); step();
    excep_flush_i = 0;
    mon();
    total++; if (preif_to_if_valid_o !== 1'b1) $display("FAIL idle_excep_wake got=%b want=1", preif_to_if_valid_o); else passed++;
    step(); mon(); step();
  endtask

  task automatic test_wrap();
    br_taken_i = 1; br_target_i = 32'hffff_fff8;
    sb.push_back(32'hffff_fff8); sb.push_back(32'h0000_0000);
    mon(); step();
    br_taken_i = 0;
    mon(); step();
    mon();
    total++; if (preif_to_if_valid_o !== 1'b1) $display("FAIL wrap_fire got=%b want=1", preif_to_if_valid_o); else passed++;
    step();
  endtask

  task automatic test_reset_pending();
    br_taken_i = 1; br_target_i = 32'h1c00_0300; if_allowin_i = 0;
    mon(); step();
    br_taken_i = 0;
    mon();
    total++; if (inst_addr_o !== 32'h1c00_0300 || inst_req_o !== 1'b0)
      $display("FAIL pend_hold got addr=%h req=%b want addr=1c000300 req=0", inst_addr_o, inst_req_o); else passed++;
    step();
    rst_n = 0;
    mon(); step();
    rst_n = 1; if_allowin_i = 1;
    sb.push_back(RST_PC);
    mon();
    total++; if (inst_req_o !== 1'b0) $display("FAIL rst2_boot_req got=%b want=0", inst_req_o); else passed++;
    step();
    mon();
    total++; if (preif_to_if_valid_o !== 1'b1) $display("FAIL rst2_fire got=%b want=1", preif_to_if_valid_o); else passed++;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_priority();
    test_stall();
    test_idle();
    test_wrap();
    test_reset_pending();
    total++;
    if (sb.size() != 0) $display("FAIL sb_leftover got=%0d want=0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
